// File: rtl/signed_sat_accumulator_if.sv
// Stream bundle for the saturating accumulator: sample input channel and
// packet-result output channel, each with its own valid/ready pair.
interface signed_sat_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  // master: the sample producer / result consumer
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );

  // slave: the accumulator itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/signed_sat_accumulator.sv
// Packet accumulator closing the loop around an external combinational signed
// adder; clamps on adder overflow and emits sum/count/sticky-saturation per packet.
module signed_sat_accumulator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  signed_sat_accumulator_if.slave   bus,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  input  logic [WIDTH-1:0]          add_s,
  input  logic                      add_ovf
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sat_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_sum_reg;
  logic [CNT_W-1:0] out_count_reg;
  logic             out_sat_reg;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;

  // Output slot frees up in the same cycle it drains, so no bubble between results.
  assign in_ready = !out_valid_reg || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // With no packet open the running sum is zero by construction.
  assign add_a = bus.in_data;
  assign add_b = (state_reg == ACCUM) ? acc_reg : '0;

  // Overflow needs matching operand signs, so the sample sign picks the limit.
  always_comb begin
    acc_next = add_s;
    sat_next = sat_reg;
    if (add_ovf) begin
      acc_next = bus.in_data[WIDTH-1] ? SAT_MIN : SAT_MAX;
      sat_next = 1'b1;
    end
    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
      out_sat_reg   <= 1'b0;
    end else begin
      if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (accept) begin
        if (bus.in_last) begin
          out_valid_reg <= 1'b1;
          out_sum_reg   <= acc_next;
          out_count_reg <= cnt_next;
          out_sat_reg   <= sat_next;
          acc_reg       <= '0;
          cnt_reg       <= '0;
          sat_reg       <= 1'b0;
          state_reg     <= IDLE;
        end else begin
          acc_reg       <= acc_next;
          cnt_reg       <= cnt_next;
          sat_reg       <= sat_next;
          state_reg     <= ACCUM;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_count = out_count_reg;
  assign bus.out_sat   = out_sat_reg;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Scoreboard bench: two accumulators (8-bit and 2-bit counters) fed the same
// directed stream, each behind a behavioural model of the signed adder.
module tb_signed_sat_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  always #5 clk = ~clk;

  signed_sat_accumulator_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
  signed_sat_accumulator_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  assign bus8.in_valid  = in_valid;
  assign bus8.in_data   = in_data;
  assign bus8.in_last   = in_last;
  assign bus8.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.in_data   = in_data;
  assign bus2.in_last   = in_last;
  assign bus2.out_ready = out_ready;

  // Environment adder: wrap-around sum plus signed-overflow flag.
  function automatic logic [8:0] adder(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = a + b;
    return {(a[7] == b[7]) && (s[7] != a[7]), s};
  endfunction

  logic [7:0] a8, b8, s8, a2, b2, s2;
  logic       o8, o2;
  assign {o8, s8} = adder(a8, b8);
  assign {o2, s2} = adder(a2, b2);

  signed_sat_accumulator #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8),
    .add_a(a8), .add_b(b8), .add_s(s8), .add_ovf(o8)
  );

  signed_sat_accumulator #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .add_a(a2), .add_b(b2), .add_s(s2), .add_ovf(o2)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic [7:0] count;
    logic       sat;
  } res_t;

  res_t q8[$];
  res_t q2[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic expect_pkt(input logic [7:0] sum, input int count, input logic sat);
    q8.push_back({sum, 8'(count), sat});
    q2.push_back({sum, 8'((count > 3) ? 3 : count), sat});
  endtask

  // Called at posedge+1; returns at posedge+1 after the sample is accepted.
  task automatic send(input logic [7:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!(bus8.in_ready && bus2.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 required in_ready=1 for data %h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: pop and compare whenever a result is handed off.
  res_t got8, got2, exp8, exp2;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus8.out_valid && bus8.out_ready) begin
        got8 = {bus8.out_sum, bus8.out_count, bus8.out_sat};
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result8: got unexpected %h required no output", got8);
        end else begin
          exp8 = q8.pop_front();
          check("result8", 32'(got8), 32'(exp8));
        end
      end
      if (bus2.out_valid && bus2.out_ready) begin
        got2 = {bus2.out_sum, 6'd0, bus2.out_count, bus2.out_sat};
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result2: got unexpected %h required no output", got2);
        end else begin
          exp2 = q2.pop_front();
          check("result2", 32'(got2), 32'(exp2));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-packet discards the partial sum
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_out_sum",   32'(bus8.out_sum),   32'd0);
    check("rst_out_count", 32'(bus8.out_count), 32'd0);
    check("rst_out_sat",   32'(bus8.out_sat),   32'd0);
    check("rst_in_ready",  32'(bus8.in_ready),  32'd1);
    check("rst_acc",       32'(b8),             32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_pkt(8'h05, 1, 1'b0);
    send(8'h05, 1'b1);

    // Clamps and plain sums, back to back
    expect_pkt(8'h7F, 2, 1'b1);
    send(8'h70, 1'b0); send(8'h70, 1'b1);
    expect_pkt(8'h0F, 3, 1'b1);
    send(8'h70, 1'b0); send(8'h70, 1'b0); send(8'h90, 1'b1);
    expect_pkt(8'h80, 2, 1'b1);
    send(8'h90, 1'b0); send(8'h90, 1'b1);
    expect_pkt(8'h00, 2, 1'b0);
    send(8'h70, 1'b0); send(8'h90, 1'b1);
    expect_pkt(8'h8F, 2, 1'b0);
    send(8'h90, 1'b0); send(8'hFF, 1'b1);

    // Backpressure: result held, input blocked
    expect_pkt(8'h22, 1, 1'b0);
    send(8'h22, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {22'd0, bus8.in_ready, bus8.out_valid, bus8.out_sum},
            {22'd0, 1'b0, 1'b1, 8'h22});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    expect_pkt(8'h01, 1, 1'b0);
    send(8'h01, 1'b1);
    @(negedge clk);
    check("bp_replace", {23'd0, bus8.out_valid, bus8.out_sum}, {23'd0, 1'b1, 8'h01});
    @(posedge clk);
    #1;

    // Input gaps mid-packet must not disturb the result
    expect_pkt(8'h0F, 3, 1'b1);
    send(8'h70, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(8'h70, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(8'h90, 1'b1);

    // Six-sample packet: 2-bit counter saturates at 3
    expect_pkt(8'h06, 6, 1'b0);
    for (int i = 0; i < 6; i++) send(8'h01, (i == 5));

    for (int i = 0; i < 20 && (q8.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    if (q8.size() != 0 || q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d results outstanding required 0/0", q8.size(), q2.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
